mc_control_fsm: RTL and testbench

Multi-cycle control unit that sequences the shared datapath (register file, ALU, immediate extender, unified instruction/data memory) one instruction at a time. It decodes the 6-bit opcode latched in the instruction register and steps through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, including the extender's sign/zero mode. It also holds fetch and memory states until the memory acknowledges.

---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/mc_control_fsm_if.sv | 35 +++
 rtl/mc_output_decode.sv | 64 ++++++
 rtl/mc_control_fsm.sv | 107 ++++++++++
 tb/tb_mc_control_fsm.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle control unit: state encoding, opcodes,
// datapath select encodings and the packed control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R)    || (op == OP_LW)   || (op == OP_SW)   ||
           (op == OP_BEQ)  || (op == OP_J)    || (op == OP_ADDI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the sequencer (master) and the shared datapath (slave).
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       ext_sel;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_sel, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_sel, illegal, state
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore decode of the sequencer state into the raw datapath control word.
module mc_output_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: the all-zero default first keeps every field assigned on every path, so no latch is inferred.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_I_WB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer. Define WAIT_STATE_EN to hold FETCH, MEM_READ
// and MEM_WRITE until mem_ready; otherwise every memory access takes one cycle.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  localparam logic [3:0] FETCH     = S_FETCH;
  localparam logic [3:0] DECODE    = S_DECODE;
  localparam logic [3:0] MEM_ADDR  = S_MEM_ADDR;
  localparam logic [3:0] MEM_READ  = S_MEM_READ;
  localparam logic [3:0] MEM_WB    = S_MEM_WB;
  localparam logic [3:0] MEM_WRITE = S_MEM_WRITE;
  localparam logic [3:0] EXECUTE   = S_EXECUTE;
  localparam logic [3:0] R_WB      = S_R_WB;
  localparam logic [3:0] BRANCH    = S_BRANCH;
  localparam logic [3:0] JUMP      = S_JUMP;
  localparam logic [3:0] I_EXEC    = S_I_EXEC;
  localparam logic [3:0] I_WB      = S_I_WB;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       ext_sel_q;
  logic       mem_ack;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;

`ifdef WAIT_STATE_EN
  assign mem_ack = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ack          = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ack) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:                      state_d = EXECUTE;
          OP_LW, OP_SW:              state_d = MEM_ADDR;
          OP_BEQ:                    state_d = BRANCH;
          OP_J:                      state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = I_EXEC;
          default:                   state_d = FETCH;
        endcase
      end
      MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ack) state_d = MEM_WB;
      MEM_WRITE: if (mem_ack) state_d = FETCH;
      EXECUTE:   state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      // MEM_WB, R_WB, BRANCH, JUMP, I_WB and unused codes all retire to FETCH
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments let every register sample pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= FETCH;
      ext_sel_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        ext_sel_q <= !((bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI));
    end
  end

  mc_output_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  // Reset blanks the whole word combinationally so write strobes drop without waiting for a clock.
  always_comb begin
    ctrl = ctrl_raw;
    if (state_q == FETCH && !mem_ack) begin
      ctrl.ir_write = 1'b0;
      ctrl.pc_write = 1'b0;
    end
    if (reset) ctrl = '0;
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.ext_sel       = reset ? 1'b1 : ext_sel_q;
  assign bus.illegal       = !reset && (state_q == DECODE) && !is_legal(bus.opcode);
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by
// cycle against hand-written control words.
module tb_mc_control_fsm;

  // Control word packing: {pc_write, pc_write_cond, iord, mem_read, mem_write,
  // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [15:0] CW_FETCH     = 16'h9410;
  localparam logic [15:0] CW_DECODE    = 16'h0030;
  localparam logic [15:0] CW_MEM_ADDR  = 16'h0060;
  localparam logic [15:0] CW_MEM_READ  = 16'h3000;
  localparam logic [15:0] CW_MEM_WB    = 16'h0180;
  localparam logic [15:0] CW_MEM_WRITE = 16'h2800;
  localparam logic [15:0] CW_EXECUTE   = 16'h0048;
  localparam logic [15:0] CW_R_WB      = 16'h0280;
  localparam logic [15:0] CW_BRANCH    = 16'h4045;
  localparam logic [15:0] CW_JUMP      = 16'h8002;
  localparam logic [15:0] CW_I_EXEC    = 16'h006C;
  localparam logic [15:0] CW_I_WB      = 16'h0080;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cw;
  assign cw = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
               bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
               bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
               bus.pc_source};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks one cycle (sampled at negedge+1), then advances to the next.
  task automatic cycle(input string tag, input logic [3:0] st, input logic [15:0] w,
                       input logic ill);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".cw"}, 32'(cw), 32'(w));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst.state", 32'(bus.state), 32'd0);
    check("rst.cw", 32'(cw), 32'd0);
    check("rst.ext_sel", 32'(bus.ext_sel), 32'd1);
    check("rst.illegal", 32'(bus.illegal), 32'd0);
    reset = 1'b0;
    #1;

    // lw: five cycles, write-back with mem_to_reg only in the last
    bus.opcode = 6'b100011;
    cycle("lw.f", 4'd0, CW_FETCH, 1'b0);
    cycle("lw.d", 4'd1, CW_DECODE, 1'b0);
    cycle("lw.a", 4'd2, CW_MEM_ADDR, 1'b0);
    cycle("lw.r", 4'd3, CW_MEM_READ, 1'b0);
    cycle("lw.wb", 4'd4, CW_MEM_WB, 1'b0);

    // R-type full instruction
    bus.opcode = 6'b000000;
    cycle("r.f", 4'd0, CW_FETCH, 1'b0);
    cycle("r.d", 4'd1, CW_DECODE, 1'b0);
    cycle("r.x", 4'd6, CW_EXECUTE, 1'b0);
    cycle("r.wb", 4'd7, CW_R_WB, 1'b0);

    // Second R-type, reset pulsed in EXECUTE
    cycle("r2.f", 4'd0, CW_FETCH, 1'b0);
    cycle("r2.d", 4'd1, CW_DECODE, 1'b0);
    check("r2.x.state", 32'(bus.state), 32'd6);
    reset = 1'b1;
    #1;
    check("midrst.state", 32'(bus.state), 32'd0);
    check("midrst.reg_write", 32'(bus.reg_write), 32'd0);
    check("midrst.cw", 32'(cw), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("postrst.mem_read", 32'(bus.mem_read), 32'd1);
    check("postrst.pc_write", 32'(bus.pc_write), 32'd1);

    // ori then addi: extender mode follows the DECODE edge
    bus.opcode = 6'b001101;
    cycle("ori.f", 4'd0, CW_FETCH, 1'b0);
    check("ori.d.ext", 32'(bus.ext_sel), 32'd1);
    cycle("ori.d", 4'd1, CW_DECODE, 1'b0);
    check("ori.x.ext", 32'(bus.ext_sel), 32'd0);
    cycle("ori.x", 4'd10, CW_I_EXEC, 1'b0);
    cycle("ori.wb", 4'd11, CW_I_WB, 1'b0);
    bus.opcode = 6'b001000;
    check("addi.f.ext", 32'(bus.ext_sel), 32'd0);
    cycle("addi.f", 4'd0, CW_FETCH, 1'b0);
    check("addi.d.ext", 32'(bus.ext_sel), 32'd0);
    cycle("addi.d", 4'd1, CW_DECODE, 1'b0);
    check("addi.x.ext", 32'(bus.ext_sel), 32'd1);
    cycle("addi.x", 4'd10, CW_I_EXEC, 1'b0);
    cycle("addi.wb", 4'd11, CW_I_WB, 1'b0);

    // beq: three cycles
    bus.opcode = 6'b000100;
    cycle("beq.f", 4'd0, CW_FETCH, 1'b0);
    cycle("beq.d", 4'd1, CW_DECODE, 1'b0);
    cycle("beq.b", 4'd8, CW_BRANCH, 1'b0);

    // j: three cycles
    bus.opcode = 6'b000010;
    cycle("j.f", 4'd0, CW_FETCH, 1'b0);
    cycle("j.d", 4'd1, CW_DECODE, 1'b0);
    cycle("j.j", 4'd9, CW_JUMP, 1'b0);

    // andi sets zero-extend; the illegal opcode that follows restores sign-extend
    bus.opcode = 6'b001100;
    cycle("andi.f", 4'd0, CW_FETCH, 1'b0);
    cycle("andi.d", 4'd1, CW_DECODE, 1'b0);
    check("andi.x.ext", 32'(bus.ext_sel), 32'd0);
    cycle("andi.x", 4'd10, CW_I_EXEC, 1'b0);
    cycle("andi.wb", 4'd11, CW_I_WB, 1'b0);

    bus.opcode = 6'b111111;
    cycle("ill.f", 4'd0, CW_FETCH, 1'b0);
    cycle("ill.d", 4'd1, CW_DECODE, 1'b1);
    check("ill.next.ext", 32'(bus.ext_sel), 32'd1);

`ifdef WAIT_STATE_EN
    // sw with a two-cycle fetch wait and a three-cycle write wait
    bus.opcode    = 6'b101011;
    bus.mem_ready = 1'b0;
    #1;
    cycle("wsw.fw0", 4'd0, 16'h1010, 1'b0);
    cycle("wsw.fw1", 4'd0, 16'h1010, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    cycle("wsw.f", 4'd0, CW_FETCH, 1'b0);
    cycle("wsw.d", 4'd1, CW_DECODE, 1'b0);
    cycle("wsw.a", 4'd2, CW_MEM_ADDR, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    cycle("wsw.w0", 4'd5, CW_MEM_WRITE, 1'b0);
    cycle("wsw.w1", 4'd5, CW_MEM_WRITE, 1'b0);
    cycle("wsw.w2", 4'd5, CW_MEM_WRITE, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    cycle("wsw.ack", 4'd5, CW_MEM_WRITE, 1'b0);
    cycle("wsw.next", 4'd0, CW_FETCH, 1'b0);
`else
    // sw with mem_ready low throughout: without wait states it is ignored
    bus.opcode    = 6'b101011;
    bus.mem_ready = 1'b0;
    #1;
    cycle("sw.f", 4'd0, CW_FETCH, 1'b0);
    cycle("sw.d", 4'd1, CW_DECODE, 1'b0);
    cycle("sw.a", 4'd2, CW_MEM_ADDR, 1'b0);
    cycle("sw.w", 4'd5, CW_MEM_WRITE, 1'b0);
    cycle("sw.next", 4'd0, CW_FETCH, 1'b0);
    bus.mem_ready = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
